// File: rtl/proc_gen.sv
// Simple multi-cycle processor: eight general registers and a shared bus.
// It supports mv, mvi and mvnz moves, a nop, and add/sub/and/xor through the A and G registers.
module proc_gen #(
   parameter int N = 16
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic [N-1:0] DIN,
   input  logic         Run,
   output logic         Done,
   output logic [N-1:0] BusWires,
   output logic         Zflag
);

   typedef enum logic [1:0] {T0, T1, T2, T3} state_e;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_MVNZ = 3'b110;
   localparam logic [2:0] OP_NOP  = 3'b111;

   state_e       state_q, state_d;
   logic [8:0]   ir_q;
   logic [N-1:0] r_q [8];
   logic [N-1:0] a_q, g_q, g_d;
   logic         z_q, z_d;
   logic         ir_we, rx_we, a_we, g_we;
   logic [2:0]   opc, rx, ry;

   assign opc   = ir_q[8:6];
   assign rx    = ir_q[5:3];
   assign ry    = ir_q[2:0];
   assign Zflag = z_q;

   always_comb begin
      state_d  = state_q;
      Done     = 1'b0;
      BusWires = '0;
      ir_we    = 1'b0;
      rx_we    = 1'b0;
      a_we     = 1'b0;
      g_we     = 1'b0;
      unique case (state_q)
         T0: begin
            if (Run) begin
               ir_we   = 1'b1;
               state_d = T1;
            end
         end
         T1: begin
            unique case (opc)
               OP_MV: begin
                  BusWires = r_q[ry];
                  rx_we    = 1'b1;
                  Done     = 1'b1;
                  state_d  = T0;
               end
               OP_MVI: begin
                  BusWires = DIN;
                  rx_we    = 1'b1;
                  Done     = 1'b1;
                  state_d  = T0;
               end
               OP_MVNZ: begin
                  BusWires = r_q[ry];
                  rx_we    = ~z_q;
                  Done     = 1'b1;
                  state_d  = T0;
               end
               OP_NOP: begin
                  Done    = 1'b1;
                  state_d = T0;
               end
               default: begin
                  BusWires = r_q[rx];
                  a_we     = 1'b1;
                  state_d  = T2;
               end
            endcase
         end
         T2: begin
            BusWires = r_q[ry];
            g_we     = 1'b1;
            state_d  = T3;
         end
         T3: begin
            BusWires = g_q;
            rx_we    = 1'b1;
            Done     = 1'b1;
            state_d  = T0;
         end
      endcase
   end

   // ALU sees A and the bus (Ry in T2); result wraps modulo 2^N
   always_comb begin
      g_d = '0;
      unique case (opc)
         OP_ADD:  g_d = a_q + BusWires;
         OP_SUB:  g_d = a_q - BusWires;
         OP_AND:  g_d = a_q & BusWires;
         OP_XOR:  g_d = a_q ^ BusWires;
         default: g_d = '0;
      endcase
      z_d = (g_d == '0);
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= T0;
         ir_q    <= '0;
         a_q     <= '0;
         g_q     <= '0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (ir_we) ir_q <= DIN[8:0];
         if (a_we) a_q <= BusWires;
         if (g_we) begin
            g_q <= g_d;
            z_q <= z_d;
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < 8; i++) r_q[i] <= '0;
      end else if (rx_we) begin
         r_q[rx] <= BusWires;
      end
   end

endmodule

// File: tb/tb_proc_gen.sv
// Randomized bench for proc_gen against an instruction-level model.
// Registers are observed on the bus through mv Rx,Rx.
module tb_proc_gen;
   localparam int N = 16;

   logic         Clock = 1'b0;
   logic         Resetn;
   logic [N-1:0] DIN;
   logic         Run;
   logic         Done;
   logic [N-1:0] BusWires;
   logic         Zflag;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0] m_r [8];
   logic         m_z;

   proc_gen #(.N(N)) dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .DIN      (DIN),
      .Run      (Run),
      .Done     (Done),
      .BusWires (BusWires),
      .Zflag    (Zflag)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_r[i] = '0;
      m_z = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Resetn = 1'b0;
      Run    = 1'b0;
      #1;
      check("rst_done", Done, 0);
      check("rst_bus", BusWires, 0);
      check("rst_z", Zflag, 0);
      @(negedge Clock);
      Resetn = 1'b1;
      model_reset();
   endtask

   function automatic logic [8:0] enc(input int op, input int x, input int y);
      logic [2:0] o, a, b;
      o = 3'(op);
      a = 3'(x);
      b = 3'(y);
      return {o, a, b};
   endfunction

   task automatic exec(input logic [8:0] ir, input logic [N-1:0] imm);
      logic [2:0]   op, x, y;
      logic [N-1:0] eb, res, bus;
      int           lat, exp_lat;
      bit           seen;
      op  = ir[8:6];
      x   = ir[5:3];
      y   = ir[2:0];
      res = '0;
      case (op)
         3'd2: res = m_r[x] + m_r[y];
         3'd3: res = m_r[x] - m_r[y];
         3'd4: res = m_r[x] & m_r[y];
         3'd5: res = m_r[x] ^ m_r[y];
         default: res = '0;
      endcase
      exp_lat = (op inside {3'd2, 3'd3, 3'd4, 3'd5}) ? 4 : 2;
      case (op)
         3'd0, 3'd6: eb = m_r[y];
         3'd1:       eb = imm;
         3'd7:       eb = '0;
         default:    eb = res;
      endcase
      @(negedge Clock);
      Run  = 1'b1;
      DIN  = {{(N-9){1'b0}}, ir};
      lat  = 1;
      seen = 1'b0;
      bus  = '0;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(negedge Clock);
         Run = 1'b0;
         DIN = imm;
         #1;
         lat++;
         if (Done) begin
            seen = 1'b1;
            bus  = BusWires;
         end
      end
      check($sformatf("lat_op%0d", op), seen ? lat : 0, exp_lat);
      check($sformatf("bus_op%0d_x%0d_y%0d", op, x, y), bus, eb);
      case (op)
         3'd0: m_r[x] = m_r[y];
         3'd1: m_r[x] = imm;
         3'd6: if (!m_z) m_r[x] = m_r[y];
         3'd7: ;
         default: begin
            m_r[x] = res;
            m_z    = (res == '0);
         end
      endcase
      check("zflag", Zflag, m_z);
   endtask

   task automatic observe(input int r);
      exec(enc(0, r, r), N'($urandom));
   endtask

   initial begin
      logic [8:0]   ir;
      logic [N-1:0] imm;
      Resetn = 1'b0;
      Run    = 1'b0;
      DIN    = '0;
      model_reset();
      do_reset();
      for (int r = 0; r < 8; r++) observe(r);

      exec(enc(1, 0, 0), 16'd5);
      exec(enc(1, 1, 0), 16'd3);
      exec(enc(2, 0, 1), 16'h1234);
      check("r0_is_8", m_r[0], 8);

      exec(enc(1, 2, 0), 16'h0001);
      exec(enc(1, 3, 0), 16'h0002);
      exec(enc(3, 2, 3), 16'h0);
      observe(2);
      exec(enc(1, 4, 0), 16'hFFFF);
      exec(enc(1, 5, 0), 16'h0001);
      exec(enc(2, 4, 5), 16'h0);
      observe(4);

      exec(enc(1, 6, 0), 16'hABCD);
      exec(enc(6, 6, 0), 16'h0);
      observe(6);
      exec(enc(1, 7, 0), 16'h00FF);
      exec(enc(1, 5, 0), 16'h000F);
      exec(enc(5, 7, 5), 16'h0);
      exec(enc(6, 6, 0), 16'h0);
      observe(6);

      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         Run = 1'b0;
         DIN = N'($urandom);
         #1;
         check("idle_done", Done, 0);
         check("idle_bus", BusWires, 0);
      end
      observe(7);

      exec(enc(1, 1, 0), 16'h1111);
      exec(enc(1, 2, 0), 16'h2222);
      @(negedge Clock);
      Run = 1'b1;
      DIN = {{(N-9){1'b0}}, enc(2, 1, 2)};
      @(negedge Clock);
      Run = 1'b0;
      @(negedge Clock);
      #1;
      check("t2_bus", BusWires, m_r[2]);
      Resetn = 1'b0;
      #1;
      check("midrst_done", Done, 0);
      check("midrst_bus", BusWires, 0);
      @(negedge Clock);
      Resetn = 1'b1;
      model_reset();
      exec(enc(1, 1, 0), 16'd7);
      for (int r = 0; r < 8; r++) observe(r);

      exec(enc(1, 0, 0), N'($urandom));
      @(negedge Clock);
      Run = 1'b1;
      DIN = {{(N-9){1'b0}}, enc(0, 1, 0)};
      #1;
      check("b2b_t0a", Done, 0);
      @(negedge Clock);
      DIN = {{(N-9){1'b0}}, enc(7, 0, 0)};
      #1;
      check("b2b_mv_done", Done, 1);
      check("b2b_mv_bus", BusWires, m_r[0]);
      m_r[1] = m_r[0];
      @(negedge Clock);
      #1;
      check("b2b_t0b", Done, 0);
      @(negedge Clock);
      Run = 1'b0;
      #1;
      check("b2b_nop_done", Done, 1);
      check("b2b_nop_bus", BusWires, 0);
      @(negedge Clock);
      #1;
      check("b2b_t0c", Done, 0);
      observe(1);

      for (int i = 0; i < 250; i++) begin
         ir = 9'($urandom);
         case ($urandom_range(0, 3))
            0:       imm = '0;
            1:       imm = '1;
            default: imm = N'($urandom);
         endcase
         exec(ir, imm);
         if (i % 16 == 0) observe(int'($urandom_range(0, 7)));
      end
      for (int r = 0; r < 8; r++) observe(r);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end
endmodule
